// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   ID-stage hazard detection and stall/flush controller. Detects load-use
//   hazards that the EXE forwarding path cannot cover, holds PC and IF/ID for
//   LOAD_STALL_CYCLES cycles while bubbling ID/EXE, and flushes IF/ID on a
//   taken branch. Branch always wins over load-use.
//
// Parameters
//   REG_ADDR_W        register-specifier width
//   LOAD_STALL_CYCLES bubbles inserted per load-use hazard (1..15)
//
// Ports
//   i_Clk, i_Rst       clock, synchronous active-high reset
//   i_MemRead_EXE      EXE instruction is a load
//   i_RegWr_EXE        EXE destination register
//   i_Rs_ID, i_Rt_ID   ID source registers
//   i_UsesRt_ID        ID instruction reads Rt
//   i_Branch_Taken     branch resolved taken in EXE
//   o_PC_Write         PC may update
//   o_IF_ID_Write      IF/ID may load
//   o_ID_EXE_Bubble    zero ID/EXE controls
//   o_IF_ID_Flush      squash IF/ID
//   o_Stall_Active     registered, FSM in LOAD_STALL
//   o_Stall_Cycles     (HAZARD_STATS_EN) saturating count of PC-held cycles
//   o_Flush_Count      (HAZARD_STATS_EN) saturating count of flush cycles
//
// Optional feature macro: HAZARD_STATS_EN
module hazard_stall_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_MemRead_EXE,
  input  logic [REG_ADDR_W-1:0] i_RegWr_EXE,
  input  logic [REG_ADDR_W-1:0] i_Rs_ID,
  input  logic [REG_ADDR_W-1:0] i_Rt_ID,
  input  logic                  i_UsesRt_ID,
  input  logic                  i_Branch_Taken,
  output logic                  o_PC_Write,
  output logic                  o_IF_ID_Write,
  output logic                  o_ID_EXE_Bubble,
  output logic                  o_IF_ID_Flush,
`ifdef HAZARD_STATS_EN
  output logic [15:0]           o_Stall_Cycles,
  output logic [15:0]           o_Flush_Count,
`endif
  output logic                  o_Stall_Active
);

  typedef enum logic {RUN, LOAD_STALL} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_hz;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign w_hz = i_MemRead_EXE && (i_RegWr_EXE != '0) &&
                ((i_RegWr_EXE == i_Rs_ID) || (i_UsesRt_ID && (i_RegWr_EXE == i_Rt_ID)));

  always_comb begin
    o_PC_Write      = 1'b1;
    o_IF_ID_Write   = 1'b1;
    o_ID_EXE_Bubble = 1'b0;
    o_IF_ID_Flush   = 1'b0;
    if (i_Rst) begin
      // defaults already give the reset values
    end else if (i_Branch_Taken) begin
      // Branch squashes the ID instruction, so any pending stall is moot.
      o_IF_ID_Flush   = 1'b1;
      o_ID_EXE_Bubble = 1'b1;
    end else if (r_state == LOAD_STALL || w_hz) begin
      o_PC_Write      = 1'b0;
      o_IF_ID_Write   = 1'b0;
      o_ID_EXE_Bubble = 1'b1;
    end
  end

  assign o_Stall_Active = (r_state == LOAD_STALL) && !i_Rst;

  // The first held cycle is spent in RUN (combinational detect), so LOAD_STALL
  // covers the remaining LOAD_STALL_CYCLES-1 cycles.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (!i_Branch_Taken && w_hz && (LOAD_STALL_CYCLES > 1)) begin
            r_state <= LOAD_STALL;
            r_cnt   <= 4'(LOAD_STALL_CYCLES - 1);
          end
        end
        LOAD_STALL: begin
          if (i_Branch_Taken || r_cnt <= 4'd1) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_stall_cycles <= 16'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (!o_PC_Write && r_stall_cycles != 16'hFFFF)
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (o_IF_ID_Flush && r_flush_count != 16'hFFFF)
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign o_Stall_Cycles = r_stall_cycles;
  assign o_Flush_Count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst, mr, ut, br;
  logic [4:0] rd, rs, rt;

  logic pc1, iw1, bb1, fl1, sa1;
  logic pc3, iw3, bb3, fl3, sa3;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, fc1, sc3, fc3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_MemRead_EXE(mr), .i_RegWr_EXE(rd),
    .i_Rs_ID(rs), .i_Rt_ID(rt), .i_UsesRt_ID(ut), .i_Branch_Taken(br),
    .o_PC_Write(pc1), .o_IF_ID_Write(iw1), .o_ID_EXE_Bubble(bb1),
    .o_IF_ID_Flush(fl1),
`ifdef HAZARD_STATS_EN
    .o_Stall_Cycles(sc1), .o_Flush_Count(fc1),
`endif
    .o_Stall_Active(sa1));

  hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) dut3 (
    .i_Clk(clk), .i_Rst(rst), .i_MemRead_EXE(mr), .i_RegWr_EXE(rd),
    .i_Rs_ID(rs), .i_Rt_ID(rt), .i_UsesRt_ID(ut), .i_Branch_Taken(br),
    .o_PC_Write(pc3), .o_IF_ID_Write(iw3), .o_ID_EXE_Bubble(bb3),
    .o_IF_ID_Flush(fl3),
`ifdef HAZARD_STATS_EN
    .o_Stall_Cycles(sc3), .o_Flush_Count(fc3),
`endif
    .o_Stall_Active(sa3));

  // Expected outputs packed as {PC_Write, IF_ID_Write, Bubble, Flush, Stall_Active}
  typedef struct {
    logic       rst, mr, ut, br;
    logic [4:0] rd, rs, rt;
    logic [4:0] e1, e3;
  } vec_t;

  localparam logic [4:0] RUNO = 5'b11000;  // free-running
  localparam logic [4:0] HLD0 = 5'b00100;  // held, FSM in RUN
  localparam logic [4:0] HLD1 = 5'b00101;  // held, FSM in LOAD_STALL
  localparam logic [4:0] FLS0 = 5'b11110;  // flush from RUN
  localparam logic [4:0] FLS1 = 5'b11111;  // flush aborting LOAD_STALL

  vec_t tv[28];

  function automatic vec_t mk(logic r, logic m, logic [4:0] d, logic [4:0] s,
                              logic [4:0] t, logic u, logic b,
                              logic [4:0] x1, logic [4:0] x3);
    vec_t v;
    v.rst = r; v.mr = m; v.rd = d; v.rs = s; v.rt = t; v.ut = u; v.br = b;
    v.e1 = x1; v.e3 = x3;
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic [4:0] o1, o3;
`ifdef HAZARD_STATS_EN
    logic [15:0] m_sc1, m_fc1, m_sc3, m_fc3;
    m_sc1 = 0; m_fc1 = 0; m_sc3 = 0; m_fc3 = 0;
`endif
    //              rst mr rd  rs  rt ut br   dut1  dut3
    tv[0]  = mk(1, 1, 3, 3, 0, 0, 0, RUNO, RUNO);  // reset overrides hazard
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, RUNO, RUNO);
    tv[2]  = mk(0, 1, 3, 3, 0, 0, 0, HLD0, HLD0);  // load-use on Rs
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, RUNO, HLD1);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, RUNO, HLD1);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, RUNO, RUNO);
    tv[6]  = mk(0, 1, 0, 0, 0, 1, 0, RUNO, RUNO);  // r0 never stalls
    tv[7]  = mk(0, 1, 7, 1, 7, 0, 0, RUNO, RUNO);  // Rt match, Rt unused
    tv[8]  = mk(0, 0, 3, 3, 0, 0, 0, RUNO, RUNO);  // not a load
    tv[9]  = mk(0, 1, 7, 1, 7, 1, 0, HLD0, HLD0);  // load-use on Rt
    tv[10] = mk(0, 1, 7, 1, 7, 1, 0, HLD0, HLD1);
    tv[11] = mk(0, 1, 7, 1, 7, 1, 0, HLD0, HLD1);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 0, RUNO, RUNO);
    tv[13] = mk(0, 1, 3, 3, 0, 0, 0, HLD0, HLD0);
    tv[14] = mk(0, 0, 0, 0, 0, 0, 1, FLS0, FLS1);  // branch in 2nd stall cycle
    tv[15] = mk(0, 0, 0, 0, 0, 0, 0, RUNO, RUNO);
    tv[16] = mk(0, 1, 3, 3, 0, 0, 1, FLS0, FLS0);  // hazard + branch together
    tv[17] = mk(0, 0, 0, 0, 0, 0, 0, RUNO, RUNO);
    tv[18] = mk(0, 1, 3, 3, 0, 0, 0, HLD0, HLD0);
    tv[19] = mk(1, 1, 3, 3, 0, 0, 0, RUNO, RUNO);  // reset mid-stall
    tv[20] = mk(0, 0, 0, 0, 0, 0, 0, RUNO, RUNO);
    tv[21] = mk(0, 1, 3, 3, 0, 0, 0, HLD0, HLD0);  // back-to-back hazards
    tv[22] = mk(0, 1, 3, 3, 0, 0, 0, HLD0, HLD1);
    tv[23] = mk(0, 1, 3, 3, 0, 0, 0, HLD0, HLD1);
    tv[24] = mk(0, 1, 3, 3, 0, 0, 0, HLD0, HLD0);
    tv[25] = mk(0, 0, 0, 0, 0, 0, 0, RUNO, HLD1);
    tv[26] = mk(0, 0, 0, 0, 0, 0, 0, RUNO, HLD1);
    tv[27] = mk(0, 0, 0, 0, 0, 0, 0, RUNO, RUNO);

    rst = 1; mr = 0; rd = 0; rs = 0; rt = 0; ut = 0; br = 0;

    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      rst = tv[i].rst; mr = tv[i].mr; rd = tv[i].rd; rs = tv[i].rs;
      rt = tv[i].rt; ut = tv[i].ut; br = tv[i].br;
      @(negedge clk);
      o1 = {pc1, iw1, bb1, fl1, sa1};
      o3 = {pc3, iw3, bb3, fl3, sa3};
      chk($sformatf("row%0d_lsc1", i), {11'd0, o1}, {11'd0, tv[i].e1});
      chk($sformatf("row%0d_lsc3", i), {11'd0, o3}, {11'd0, tv[i].e3});
`ifdef HAZARD_STATS_EN
      chk($sformatf("row%0d_stall1", i), sc1, m_sc1);
      chk($sformatf("row%0d_flush1", i), fc1, m_fc1);
      chk($sformatf("row%0d_stall3", i), sc3, m_sc3);
      chk($sformatf("row%0d_flush3", i), fc3, m_fc3);
      if (tv[i].rst) begin
        m_sc1 = 0; m_fc1 = 0; m_sc3 = 0; m_fc3 = 0;
      end else begin
        m_sc1 += {15'd0, ~tv[i].e1[4]};
        m_fc1 += {15'd0, tv[i].e1[1]};
        m_sc3 += {15'd0, ~tv[i].e3[4]};
        m_fc3 += {15'd0, tv[i].e3[1]};
      end
`endif
    end

`ifdef HAZARD_STATS_EN
    // Scenarios 3 and 4 on the 3-cycle unit, from a clean reset.
    @(posedge clk); #1;
    rst = 1; mr = 0; rd = 0; rs = 0; rt = 0; ut = 0; br = 0;
    @(posedge clk); #1;
    rst = 0; mr = 1; rd = 7; rs = 1; rt = 7; ut = 1;
    repeat (3) @(posedge clk);
    #1; mr = 0; rd = 0; rs = 0; rt = 0; ut = 0;
    @(posedge clk); #1; mr = 1; rd = 3; rs = 3;
    @(posedge clk); #1; mr = 0; rd = 0; rs = 0; br = 1;
    @(posedge clk); #1; br = 0;
    @(posedge clk); #1;
    chk("seq_stall_cycles", sc3, 16'd4);
    chk("seq_flush_count",  fc3, 16'd1);

    // Saturation: continuous hazard on the 1-cycle unit stalls every cycle.
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mr = 1; rd = 3; rs = 3;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", sc1, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_ffff", sc1, 16'hFFFF);
    chk("sat_flush_zero", fc1, 16'd0);
    mr = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
